// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode decode, bit-count type and FSM state encodings,
// used by both spi_slave and spi_master.
package spi_pkg;

    localparam int BIT_CNT_W = 3;
    typedef logic [BIT_CNT_W-1:0] bit_cnt_t;
    localparam bit_cnt_t BIT_CNT_MAX = 3'd7;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    // Mode encoding: CPOL = mode 2|3, CPHA = mode 1|3.
    function automatic logic mode_cpol(input int mode);
        return (mode == 2) || (mode == 3);
    endfunction

    function automatic logic mode_cpha(input int mode);
        return (mode == 1) || (mode == 3);
    endfunction

endpackage

// File: rtl/spi_slave_if.sv
// Byte-level handshake between spi_slave and on-chip register/control logic.
interface spi_slave_if;

    logic [7:0] i_TX_Byte;
    logic       i_TX_DV;
    logic       o_TX_Ready;
    logic       o_RX_DV;
    logic [7:0] o_RX_Byte;
    logic       o_CS_Active;

    modport slave (
        input  i_TX_Byte, i_TX_DV,
        output o_TX_Ready, o_RX_DV, o_RX_Byte, o_CS_Active
    );

    modport master (
        output i_TX_Byte, i_TX_DV,
        input  o_TX_Ready, o_RX_DV, o_RX_Byte, o_CS_Active
    );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, followed by one extra
// flop that turns level changes into single-cycle rise/fall pulses.
module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Async,
    output logic o_Rise,
    output logic o_Fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic              sync_s;

    // NOTE: non-blocking assignments keep every stage sampling the previous
    // stage's old value, which is what makes this a shift chain.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], i_Async};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign sync_s = sync_q[STAGES-1];
    assign o_Rise = sync_s & ~prev_q;
    assign o_Fall = ~sync_s & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI slave endpoint oversampled on i_Clk, one byte per 8 SCLK cycles, MSb first.
// Optional SPI_SLAVE_MISO_OE_EN adds o_SPI_MISO_OE for a shared-MISO tristate.
module spi_slave
    import spi_pkg::*;
#(
    parameter int         SPI_MODE     = 0,
    parameter int         SYNC_STAGES  = 2,
    parameter logic [7:0] IDLE_TX_BYTE = 8'hFF
) (
    input  logic        i_Clk,
    input  logic        i_Rst_L,
    spi_slave_if.slave  bus,
    input  logic        i_SPI_Clk,
    input  logic        i_SPI_CS_n,
    input  logic        i_SPI_MOSI,
    output logic        o_SPI_MISO
`ifdef SPI_SLAVE_MISO_OE_EN
    ,
    output logic        o_SPI_MISO_OE
`endif
);

    localparam logic CPOL = mode_cpol(SPI_MODE);
    localparam logic CPHA = mode_cpha(SPI_MODE);

    logic       sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic       mosi_s;

    logic [0:0] state;
    logic [7:0] tx_buf;
    logic       tx_full;
    logic [7:0] tx_shift;
    bit_cnt_t   tx_cnt, tx_cnt_dec;
    logic [6:0] rx_shift;
    bit_cnt_t   rx_cnt;
    logic [7:0] rx_byte;
    logic       rx_dv;

    logic       lead_edge, trail_edge, frame_on, abort;
    logic       sample_edge, shift_edge, byte_done, byte_start;
    logic [7:0] load_byte;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(CPOL)) u_sclk_sync (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_Async (i_SPI_Clk),
        .o_Rise  (sclk_rise),
        .o_Fall  (sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_Async (i_SPI_CS_n),
        .o_Rise  (cs_rise),
        .o_Fall  (cs_fall)
    );

    // Same depth as SCLK so MOSI stays aligned with the detected clock edge.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) mosi_sync_q <= '0;
        else          mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], i_SPI_MOSI};
    end
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
    assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
    assign frame_on    = (state == ST_ACTIVE) && !cs_rise;
    assign abort       = (state == ST_ACTIVE) && cs_rise;
    assign sample_edge = frame_on && (CPHA ? trail_edge : lead_edge);
    assign shift_edge  = frame_on && (CPHA ? lead_edge : trail_edge);
    assign byte_done   = sample_edge && (rx_cnt == '0);
    assign byte_start  = ((state == ST_IDLE) && cs_fall) || byte_done;
    assign load_byte   = tx_full ? tx_buf : IDLE_TX_BYTE;
    assign tx_cnt_dec  = tx_cnt - 3'd1;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state <= ST_IDLE;
        end else if (state == ST_IDLE && cs_fall) begin
            state <= ST_ACTIVE;
        end else if (abort) begin
            state <= ST_IDLE;
        end
    end

    // A write in the byte-start cycle wins: the old byte is already on its
    // way into tx_shift, the new one stays buffered.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            tx_buf  <= 8'h00;
            tx_full <= 1'b0;
        end else if (bus.i_TX_DV) begin
            tx_buf  <= bus.i_TX_Byte;
            tx_full <= 1'b1;
        end else if (byte_start) begin
            tx_full <= 1'b0;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            tx_shift   <= IDLE_TX_BYTE;
            tx_cnt     <= BIT_CNT_MAX;
            o_SPI_MISO <= IDLE_TX_BYTE[7];
        end else if (abort) begin
            tx_cnt <= BIT_CNT_MAX;
        end else if (byte_start) begin
            tx_shift <= load_byte;
            tx_cnt   <= BIT_CNT_MAX;
            if (!CPHA) o_SPI_MISO <= load_byte[7];
        end else if (shift_edge) begin
            if (CPHA) begin
                o_SPI_MISO <= tx_shift[tx_cnt];
                tx_cnt     <= tx_cnt_dec;
            end else if (rx_cnt != BIT_CNT_MAX) begin
                // The trailing edge right after the 8th sample must not
                // disturb the next byte's bit 7, already on MISO.
                o_SPI_MISO <= tx_shift[tx_cnt_dec];
                tx_cnt     <= tx_cnt_dec;
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            rx_shift <= '0;
            rx_cnt   <= BIT_CNT_MAX;
            rx_byte  <= 8'h00;
            rx_dv    <= 1'b0;
        end else begin
            // NOTE: default-low assignment first makes rx_dv a one-cycle pulse
            // without needing an else branch on every path.
            rx_dv <= 1'b0;
            if (abort) begin
                rx_cnt <= BIT_CNT_MAX;
            end else if (sample_edge) begin
                rx_shift <= {rx_shift[5:0], mosi_s};
                if (rx_cnt == '0) begin
                    rx_byte <= {rx_shift, mosi_s};
                    rx_dv   <= 1'b1;
                    rx_cnt  <= BIT_CNT_MAX;
                end else begin
                    rx_cnt <= rx_cnt - 3'd1;
                end
            end
        end
    end

    assign bus.o_TX_Ready  = ~tx_full;
    assign bus.o_RX_DV     = rx_dv;
    assign bus.o_RX_Byte   = rx_byte;
    assign bus.o_CS_Active = (state == ST_ACTIVE);

`ifdef SPI_SLAVE_MISO_OE_EN
    assign o_SPI_MISO_OE = (state == ST_ACTIVE);
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: one DUT per SPI mode, a bit-banged master model, and a
// scoreboard that matches every o_RX_DV pulse against the queued expected byte.
module tb_spi_slave;

    localparam int SYNC = 2;
    localparam int H    = 8;   // i_Clk cycles per SCLK half period

    typedef struct {
        int         mode;
        logic [7:0] data;
    } exp_t;

    logic       clk;
    logic       rst_l;
    logic [3:0] sclk, cs_n, mosi, miso;
    logic [3:0] tx_dv, tx_ready, rx_dv, cs_active;
    logic [7:0] tx_byte [4];
    logic [7:0] rx_byte [4];
`ifdef SPI_SLAVE_MISO_OE_EN
    logic [3:0] miso_oe;
`endif

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave_if u_if ();

        assign u_if.i_TX_Byte = tx_byte[g];
        assign u_if.i_TX_DV   = tx_dv[g];
        assign tx_ready[g]    = u_if.o_TX_Ready;
        assign rx_dv[g]       = u_if.o_RX_DV;
        assign rx_byte[g]     = u_if.o_RX_Byte;
        assign cs_active[g]   = u_if.o_CS_Active;

        spi_slave #(
            .SPI_MODE     (g),
            .SYNC_STAGES  (SYNC),
            .IDLE_TX_BYTE (8'hFF)
        ) u_dut (
            .i_Clk      (clk),
            .i_Rst_L    (rst_l),
            .bus        (u_if.slave),
            .i_SPI_Clk  (sclk[g]),
            .i_SPI_CS_n (cs_n[g]),
            .i_SPI_MOSI (mosi[g]),
            .o_SPI_MISO (miso[g])
`ifdef SPI_SLAVE_MISO_OE_EN
            ,
            .o_SPI_MISO_OE (miso_oe[g])
`endif
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge away from DUT updates.
    always @(negedge clk) begin
        for (int m = 0; m < 4; m++) begin
            if (rx_dv[m] === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL rx_unexpected: mode %0d got %h, none expected", m, rx_byte[m]);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.mode != m || e.data !== rx_byte[m]) begin
                        bad++;
                        $display("FAIL rx_byte: mode %0d got %h expected mode %0d byte %h",
                                 m, rx_byte[m], e.mode, e.data);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_tx(input int m, input logic [7:0] b);
        @(negedge clk);
        tx_byte[m] = b;
        tx_dv[m]   = 1'b1;
        @(negedge clk);
        tx_dv[m]   = 1'b0;
    endtask

    task automatic expect_rx(input int m, input logic [7:0] b);
        exp_t e;
        e.mode = m;
        e.data = b;
        exp_q.push_back(e);
    endtask

    task automatic cs_low(input int m);
        @(negedge clk);
        cs_n[m] = 1'b0;
    endtask

    task automatic cs_high(input int m);
        wait_clks(H);
        cs_n[m] = 1'b1;
        wait_clks(2 * H);
    endtask

    // Master side: drives nbits of tx MSb first, returns the MISO bits seen.
    task automatic xfer(input int m, input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        logic cpol, cpha;
        cpol = (m >= 2);
        cpha = (m == 1) || (m == 3);
        rx   = 8'h00;
        wait_clks(H);
        for (int i = 7; i > 7 - nbits; i--) begin
            if (!cpha) begin
                mosi[m] = tx[i];
                wait_clks(H);
                sclk[m] = ~cpol;
                rx      = {rx[6:0], miso[m]};
                wait_clks(H);
                sclk[m] = cpol;
            end else begin
                sclk[m] = ~cpol;
                mosi[m] = tx[i];
                wait_clks(H);
                sclk[m] = cpol;
                rx      = {rx[6:0], miso[m]};
                wait_clks(H);
            end
        end
    endtask

    initial begin
        logic [7:0] got;
        int         n;

        sclk  = 4'b1100;
        cs_n  = 4'b1111;
        mosi  = 4'b0000;
        tx_dv = 4'b0000;
        for (int m = 0; m < 4; m++) tx_byte[m] = 8'h00;
        rst_l = 1'b1;
        #1 rst_l = 1'b0;
        wait_clks(5);
        rst_l = 1'b1;
        wait_clks(5);

        for (int m = 0; m < 4; m++) begin
            check($sformatf("reset_tx_ready_m%0d", m), tx_ready[m], 1);
            check($sformatf("reset_rx_dv_m%0d", m), rx_dv[m], 0);
            check($sformatf("reset_rx_byte_m%0d", m), rx_byte[m], 8'h00);
            check($sformatf("reset_cs_active_m%0d", m), cs_active[m], 0);
            check($sformatf("reset_miso_m%0d", m), miso[m], 1);
        end

        // Mode 0: A5 in, 3C out.
        load_tx(0, 8'h3C);
        check("tx_ready_after_load", tx_ready[0], 0);
        expect_rx(0, 8'hA5);
        cs_low(0);
        wait_clks(6);
        check("cs_active_in_frame", cs_active[0], 1);
`ifdef SPI_SLAVE_MISO_OE_EN
        check("miso_oe_in_frame", miso_oe[0], 1);
`endif
        xfer(0, 8'hA5, 8, got);
        check("m0_miso_byte", got, 8'h3C);
        check("tx_ready_after_consume", tx_ready[0], 1);
        cs_high(0);
        check("cs_active_after_frame", cs_active[0], 0);

        // Modes 1..3: 5A in, C3 out.
        for (int m = 1; m < 4; m++) begin
            load_tx(m, 8'hC3);
            expect_rx(m, 8'h5A);
            cs_low(m);
            xfer(m, 8'h5A, 8, got);
            check($sformatf("m%0d_miso_byte", m), got, 8'hC3);
            cs_high(m);
        end

        // Three bytes under one CS, only 01 and 02 supplied.
        load_tx(0, 8'h01);
        expect_rx(0, 8'h10);
        expect_rx(0, 8'h20);
        expect_rx(0, 8'h30);
        cs_low(0);
        fork
            begin
                xfer(0, 8'h10, 8, got);
                check("burst_miso_0", got, 8'h01);
                xfer(0, 8'h20, 8, got);
                check("burst_miso_1", got, 8'h02);
                xfer(0, 8'h30, 8, got);
                check("burst_miso_2", got, 8'hFF);
            end
            begin
                n = 0;
                while (tx_ready[0] !== 1'b1 && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                check("burst_tx_ready_wait", tx_ready[0], 1);
                load_tx(0, 8'h02);
            end
        join
        cs_high(0);

        // Abort after 5 bits, then a clean 77.
        cs_low(0);
        xfer(0, 8'hF0, 5, got);
        cs_high(0);
        check("abort_cs_active", cs_active[0], 0);
        expect_rx(0, 8'h77);
        cs_low(0);
        xfer(0, 8'h77, 8, got);
        check("after_abort_miso", got, 8'hFF);
        cs_high(0);

        // TX write in the same cycle as the CS-fall byte start.
        load_tx(0, 8'h11);
        expect_rx(0, 8'hB4);
        expect_rx(0, 8'h6D);
        cs_low(0);
        repeat (SYNC) @(negedge clk);
        tx_byte[0] = 8'h22;
        tx_dv[0]   = 1'b1;
        @(negedge clk);
        tx_dv[0]   = 1'b0;
        wait_clks(3);
        check("coincident_tx_ready", tx_ready[0], 0);
        xfer(0, 8'hB4, 8, got);
        check("coincident_miso_0", got, 8'h11);
        xfer(0, 8'h6D, 8, got);
        check("coincident_miso_1", got, 8'h22);
        cs_high(0);

        // Async reset mid-byte with the buffer full.
        cs_low(0);
        xfer(0, 8'hFF, 4, got);
        load_tx(0, 8'h55);
        check("pre_reset_tx_ready", tx_ready[0], 0);
        @(negedge clk);
        rst_l = 1'b0;
        #1;
        check("midreset_tx_ready", tx_ready[0], 1);
        check("midreset_rx_dv", rx_dv[0], 0);
        check("midreset_rx_byte", rx_byte[0], 8'h00);
        check("midreset_cs_active", cs_active[0], 0);
        check("midreset_miso", miso[0], 1);
        cs_n[0] = 1'b1;
        wait_clks(4);
        rst_l = 1'b1;
        wait_clks(4);
        expect_rx(0, 8'h81);
        cs_low(0);
        xfer(0, 8'h81, 8, got);
        check("post_reset_miso", got, 8'hFF);
        cs_high(0);

        wait_clks(20);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
